keypad_emulator: RTL and testbench

- Responder side of the 4x4 matrix keypad interface: watches the column strobes driven by the keypad scanner and pulls the matching row line low while an emulated key is "pressed".
- Replaces the physical keypad on GPIO for hardware-in-loop and self-test, so the scanner, debouncer and display path run without a human.
- Accepts one key code per ready/valid handshake.
- Plays a timed press sequence: optional bounce-in, stable hold, optional bounce-out, then a release gap.

---
 rtl/keypad_emulator.sv | 204 ++++++++++++++++++++
 tb/tb_keypad_emulator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// keypad_emulator: stands in for a 4x4 matrix keypad, pulling the matching row low while a key is pressed.
// Optional contact bounce around the stable hold is built when KEYPAD_EMU_BOUNCE_EN is defined.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES   = 20000,
  parameter int unsigned GAP_CYCLES    = 20000,
  parameter int unsigned BOUNCE_CYCLES = 2000,
  parameter int unsigned BOUNCE_TOGGLE = 100,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOGGLE_LOAD = CNT_W'(BOUNCE_TOGGLE - 1);
  localparam bit               BOUNCE_ON   = (BOUNCE_CYCLES != 0);
  typedef enum logic [2:0] {S_IDLE, S_BOUNCE_IN, S_HOLD, S_BOUNCE_OUT, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;
`endif

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [3:0]       r_code, w_code_next;
  logic [3:0]       r_rows;
  logic             r_done, w_done_next;
  logic             w_contact;
  logic [3:0]       w_rc;
  logic [3:0]       w_row_pat;
  logic             w_col_hit;

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [CNT_W-1:0] r_tog, w_tog_next;
  logic             r_phase, w_phase_next;
`endif

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_code_next  = r_code;
    w_done_next  = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
    w_tog_next   = r_tog;
    w_phase_next = r_phase;
    // Contact phase flips every BOUNCE_TOGGLE cycles while inside either bounce window.
    if (r_state == S_BOUNCE_IN || r_state == S_BOUNCE_OUT) begin
      if (r_tog == '0) begin
        w_tog_next   = TOGGLE_LOAD;
        w_phase_next = ~r_phase;
      end else begin
        w_tog_next = r_tog - CNT_ONE;
      end
    end
`endif
    case (r_state)
      S_IDLE: begin
        if (key_valid) begin
          w_code_next  = key_code;
          w_state_next = S_HOLD;
          w_cnt_next   = HOLD_LOAD;
`ifdef KEYPAD_EMU_BOUNCE_EN
          if (BOUNCE_ON) begin
            w_state_next = S_BOUNCE_IN;
            w_cnt_next   = BOUNCE_LOAD;
            w_tog_next   = TOGGLE_LOAD;
            w_phase_next = 1'b1;
          end
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      S_BOUNCE_IN: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end else begin
          w_state_next = S_HOLD;
          w_cnt_next   = HOLD_LOAD;
        end
      end
`endif
      S_HOLD: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end else begin
          w_state_next = S_GAP;
          w_cnt_next   = GAP_LOAD;
`ifdef KEYPAD_EMU_BOUNCE_EN
          if (BOUNCE_ON) begin
            w_state_next = S_BOUNCE_OUT;
            w_cnt_next   = BOUNCE_LOAD;
            w_tog_next   = TOGGLE_LOAD;
            w_phase_next = 1'b0;
          end
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      S_BOUNCE_OUT: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end else begin
          w_state_next = S_GAP;
          w_cnt_next   = GAP_LOAD;
        end
      end
`endif
      S_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end else begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      r_cnt   <= '0;
      r_code  <= 4'h0;
      r_done  <= 1'b0;
      r_rows  <= 4'b1111;
`ifdef KEYPAD_EMU_BOUNCE_EN
      r_tog   <= '0;
      r_phase <= 1'b0;
`endif
    end else begin
      r_cnt   <= w_cnt_next;
      r_code  <= w_code_next;
      r_done  <= w_done_next;
      r_rows  <= (w_contact && w_col_hit) ? w_row_pat : 4'b1111;
`ifdef KEYPAD_EMU_BOUNCE_EN
      r_tog   <= w_tog_next;
      r_phase <= w_phase_next;
`endif
    end
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  assign w_contact = (r_state == S_HOLD) ||
                     ((r_state == S_BOUNCE_IN || r_state == S_BOUNCE_OUT) && r_phase);
`else
  assign w_contact = (r_state == S_HOLD);
`endif

  // Scanner encoding to {row, column} of the physical matrix.
  always_comb begin
    w_rc = 4'b0000;
    case (r_code)
      4'h1: w_rc = 4'b00_00;
      4'h2: w_rc = 4'b00_01;
      4'h3: w_rc = 4'b00_10;
      4'hA: w_rc = 4'b00_11;
      4'h4: w_rc = 4'b01_00;
      4'h5: w_rc = 4'b01_01;
      4'h6: w_rc = 4'b01_10;
      4'hB: w_rc = 4'b01_11;
      4'h7: w_rc = 4'b10_00;
      4'h8: w_rc = 4'b10_01;
      4'h9: w_rc = 4'b10_10;
      4'hC: w_rc = 4'b10_11;
      4'hE: w_rc = 4'b11_00;
      4'h0: w_rc = 4'b11_01;
      4'hF: w_rc = 4'b11_10;
      4'hD: w_rc = 4'b11_11;
      default: w_rc = 4'b0000;
    endcase
  end

  assign w_row_pat = ~(4'b1000 >> w_rc[3:2]);
  assign w_col_hit = ~cols[2'd3 - w_rc[1:0]];

  assign rows      = r_rows;
  assign key_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_keypad_emulator;

  localparam int HOLD   = 20;
  localparam int GAP    = 10;
  localparam int BOUNCE = 6;
  localparam int TOGGLE = 2;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int L = BOUNCE + HOLD + BOUNCE + GAP;
`else
  localparam int L = HOLD + GAP;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] key_code = 4'h0;
  logic       key_valid = 1'b0;
  logic [3:0] cols = 4'b1111;
  logic       key_ready;
  logic [3:0] rows;
  logic       busy;
  logic       done;

  typedef struct {
    int         cyc;
    logic [3:0] rows;
    logic       ready;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   done_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  keypad_emulator #(
    .HOLD_CYCLES  (HOLD),
    .GAP_CYCLES   (GAP),
    .BOUNCE_CYCLES(BOUNCE),
    .BOUNCE_TOGGLE(TOGGLE),
    .CNT_W        (8)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .cols     (cols),
    .rows     (rows),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Contact state j cycles after the accept edge, straight from the press-sequence description.
  function automatic bit contact_at(input int j);
`ifdef KEYPAD_EMU_BOUNCE_EN
    if (j < BOUNCE) return ((j / TOGGLE) % 2) == 0;
    if (j < BOUNCE + HOLD) return 1'b1;
    if (j < 2 * BOUNCE + HOLD) return (((j - BOUNCE - HOLD) / TOGGLE) % 2) == 1;
    return 1'b0;
`else
    return j < HOLD;
`endif
  endfunction

  task automatic push_seq(input int k, input logic [3:0] pat);
    exp_t e;
    for (int o = 0; o <= L; o++) begin
      e.cyc   = k + o;
      e.rows  = (o >= 1 && contact_at(o - 1)) ? pat : 4'b1111;
      e.busy  = (o < L);
      e.ready = (o == L);
      e.done  = (o == L);
      sb.push_back(e);
    end
    done_q.push_back(k + L);
  endtask

  task automatic push_idle(input int start, input int n);
    exp_t e;
    for (int o = 0; o < n; o++) begin
      e.cyc   = start + o;
      e.rows  = 4'b1111;
      e.busy  = 1'b0;
      e.ready = 1'b1;
      e.done  = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (key_ready !== 1'b1 && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (key_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=%b required=1", key_ready);
    end
  endtask

  task automatic run_seq(input logic [3:0] code, input logic [3:0] c, input logic [3:0] pat,
                         input bit pulse_busy);
    int k;
    wait_ready();
    cols      = c;
    key_code  = code;
    key_valid = 1'b1;
    k         = cyc + 1;
    push_seq(k, pat);
    @(negedge CLOCK_50);
    key_valid = 1'b0;
    key_code  = ~code;
    if (pulse_busy) begin
      repeat (4) @(negedge CLOCK_50);
      key_code  = 4'h9;
      key_valid = 1'b1;
      @(negedge CLOCK_50);
      key_valid = 1'b0;
      key_code  = ~code;
    end
    while (cyc < k + L) @(negedge CLOCK_50);
    push_idle(k + L + 1, 4);
    repeat (4) @(negedge CLOCK_50);
  endtask

  always @(negedge CLOCK_50) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || rows !== e.rows || key_ready !== e.ready || busy !== e.busy ||
          done !== e.done) begin
        failures++;
        $display("FAIL sb cyc=%0d/%0d rows=%b/%b ready=%b/%b busy=%b/%b done=%b/%b (actual/required)",
                 cyc, e.cyc, rows, e.rows, key_ready, e.ready, busy, e.busy, done, e.done);
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        failures++;
        $display("FAIL done_spurious actual_cyc=%0d required=none", cyc);
      end else if (done_q[0] != cyc) begin
        failures++;
        $display("FAIL done_cycle actual=%0d required=%0d", cyc, done_q[0]);
        void'(done_q.pop_front());
      end else begin
        void'(done_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int n;
    cols = 4'b0111;
    #1 Reset = 1'b0;
    #1;
    chk("rst_rows", rows, 4'b1111);
    chk("rst_ready", {3'b0, key_ready}, 4'd1);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_done", {3'b0, done}, 4'd0);
    repeat (3) @(negedge CLOCK_50);
    chk("rst_rows_clk", rows, 4'b1111);
    Reset = 1'b1;
    push_idle(cyc + 1, 3);
    repeat (3) @(negedge CLOCK_50);

    run_seq(4'h5, 4'b1011, 4'b1011, 1'b1);
    run_seq(4'h5, 4'b0111, 4'b1111, 1'b0);
    run_seq(4'hD, 4'b1110, 4'b1110, 1'b0);
    run_seq(4'hE, 4'b0111, 4'b1110, 1'b0);
    run_seq(4'h1, 4'b0111, 4'b0111, 1'b0);

    // key_valid held across the done cycle starts the next press immediately
    wait_ready();
    cols      = 4'b1011;
    key_code  = 4'h5;
    key_valid = 1'b1;
    k         = cyc + 1;
    push_seq(k, 4'b1011);
    @(negedge CLOCK_50);
    key_code = 4'h8;
    while (cyc < k + L) @(negedge CLOCK_50);
    push_seq(k + L + 1, 4'b1101);
    @(negedge CLOCK_50);
    key_valid = 1'b0;
    key_code  = 4'h7;
    k         = k + L + 1;
    while (cyc < k + L) @(negedge CLOCK_50);
    push_idle(k + L + 1, 4);
    repeat (4) @(negedge CLOCK_50);

    // asynchronous reset in the middle of HOLD
    wait_ready();
    cols      = 4'b1011;
    key_code  = 4'h5;
    key_valid = 1'b1;
    k         = cyc + 1;
    push_seq(k, 4'b1011);
    @(negedge CLOCK_50);
    key_valid = 1'b0;
    while (cyc < k + 14) @(negedge CLOCK_50);
    sb.delete();
    done_q.delete();
    chk("mid_hold_rows", rows, 4'b1011);
    Reset = 1'b0;
    #1;
    chk("async_rst_rows", rows, 4'b1111);
    chk("async_rst_ready", {3'b0, key_ready}, 4'd1);
    chk("async_rst_busy", {3'b0, busy}, 4'd0);
    chk("async_rst_done", {3'b0, done}, 4'd0);
    repeat (2) @(negedge CLOCK_50);
    Reset = 1'b1;
    push_idle(cyc + 1, 30);
    repeat (30) @(negedge CLOCK_50);

    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++;
    if (sb.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL leftover actual=%0d/%0d required=0/0", sb.size(), done_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
